// File: rtl/alu_logic_result_stage.sv
// Result select, status flags and a 2-entry elastic buffer behind the logic unit.
// Counts every result handed to the consumer.
module alu_logic_result_stage #(
  parameter int WIDTH     = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           in_op,
  input  logic [WIDTH-1:0]     or_in,
  input  logic [WIDTH-1:0]     nor_in,
  input  logic [WIDTH-1:0]     xor_in,
  input  logic [WIDTH-1:0]     xnor_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_result,
  output logic                 out_zero,
  output logic                 out_neg,
  output logic                 out_parity,
  output logic                 out_err,
  output logic [CNT_WIDTH-1:0] result_count
);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             neg;
    logic             parity;
    logic             err;
  } entry_t;

  entry_t                 mem [2];
  entry_t                 new_e;
  logic                   wr_ptr;
  logic                   rd_ptr;
  logic [1:0]             count;
  logic [CNT_WIDTH-1:0]   cnt_q;
  logic                   push;
  logic                   pop;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    new_e = '0;
    unique case (1'b1)
      (in_op == 3'b000): new_e.result = or_in;
      (in_op == 3'b001): new_e.result = nor_in;
      (in_op == 3'b010): new_e.result = xor_in;
      (in_op == 3'b011): new_e.result = xnor_in;
      default:           new_e.result = '0;
    endcase
    // Illegal ops carry a forced zero result with only zero/err raised.
    if (in_op[2]) begin
      new_e.err  = 1'b1;
      new_e.zero = 1'b1;
    end else begin
      new_e.zero   = (new_e.result == '0);
      new_e.neg    = new_e.result[WIDTH-1];
      new_e.parity = ^new_e.result;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      cnt_q  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= new_e;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
        cnt_q  <= cnt_q + CNT_WIDTH'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign out_result   = mem[rd_ptr].result;
  assign out_zero     = mem[rd_ptr].zero;
  assign out_neg      = mem[rd_ptr].neg;
  assign out_parity   = mem[rd_ptr].parity;
  assign out_err      = mem[rd_ptr].err;
  assign result_count = cnt_q;

endmodule

// File: doc/alu_logic_result_stage.md
# alu_logic_result_stage

Registered output stage directly downstream of the 16-bit logic unit in the ALU datapath. It selects one of the four logic results (OR, NOR, XOR, XNOR) by opcode and computes status flags. Results are queued in a 2-entry elastic buffer with valid/ready handshakes on both sides, and a count of delivered results is kept. It decouples the combinational logic unit from the ALU writeback/consumer.

## Interface
Parameters:
- WIDTH, 16, datapath width of results and flags logic
- CNT_WIDTH, 16, width of delivered-result counter

Ports:
- clk  input  1  single clock, all state updates on rising edge
- rst_n  input  1  synchronous, active-low reset
- in_valid  input  1  upstream result set and opcode are valid this cycle
- in_ready  output  1  stage can accept a result this cycle
- in_op  input  3  operation select: 000 OR, 001 NOR, 010 XOR, 011 XNOR, 100–111 illegal
- or_in  input  WIDTH  OR result from logic unit
- nor_in  input  WIDTH  NOR result from logic unit
- xor_in  input  WIDTH  XOR result from logic unit
- xnor_in  input  WIDTH  XNOR result from logic unit
- out_valid  output  1  head entry valid
- out_ready  input  1  consumer accepts head entry this cycle
- out_result  output  WIDTH  selected result of head entry
- out_zero  output  1  head result == 0
- out_neg  output  1  head result MSB
- out_parity  output  1  XOR-reduction of head result (1 = odd number of ones)
- out_err  output  1  head entry came from an illegal opcode
- result_count  output  CNT_WIDTH  number of completed output handshakes, modulo 2^CNT_WIDTH

## Operation
- Push: in_valid && in_ready. Selected result and flags are computed combinationally from the inputs and written into the tail entry.
- Illegal opcode (100–111): stored result = 0, err = 1, zero = 1, neg = 0, parity = 0. Still occupies an entry and is still delivered.
- Pop: out_valid && out_ready. Head is removed; result_count increments by 1. It wraps from 2^CNT_WIDTH−1 to 0 with no flag.
- Buffer: 2 entries, circular, with 1-bit read/write pointers and a 2-bit occupancy count (0, 1, 2).
- in_ready = (count != 2). It is a registered function of occupancy and does not depend combinationally on out_ready.
- out_valid = (count != 0). out_* fields always reflect the head entry. When out_valid = 0, out_* data hold their last value (don't-care for checking).
- Simultaneous push and pop:
  - count 1: count stays 1, both pointers advance.
  - count 0: only the push occurs, because there is no head to pop.
  - count 2: the push is blocked by in_ready = 0; the pop proceeds and count becomes 1.
- Inputs are ignored while in_valid = 0 or in_ready = 0. No state change.
- Once out_valid = 1, the head entry and its flags stay stable until popped.

## Timing
- Latency: a result pushed at edge N is presented on out_* with out_valid = 1 after edge N (the following cycle) when the buffer was empty. Minimum latency 1 cycle.
- Throughput: 1 result/cycle while out_ready is held high.
- Backpressure: with out_ready low, the stage absorbs 2 results, then in_ready drops the cycle after the second push.
- in_ready rises the cycle after the first pop from full.
- Reset (rst_n = 0 sampled at a rising edge):
  - count = 0 and pointers = 0, so out_valid = 0 and in_ready = 1.
  - out_result = 0, out_zero = 0, out_neg = 0, out_parity = 0, out_err = 0, result_count = 0.
- Reset mid-operation discards all queued entries. No handshake completes on the reset edge, and result_count does not increment.
- First push is accepted at the first rising edge with rst_n = 1.

## Test plan
- Single OR result: or_in = 0x00F0, in_op = 000, one push, out_ready = 1.
  - Next cycle: out_result = 0x00F0, zero 0, neg 0, parity 0, err 0.
  - After the pop: result_count = 1.
- XNOR all ones and XOR zero, back to back:
  - Push 1: xnor_in = 0xFFFF, op 011. Expect result 0xFFFF, neg 1, parity 0.
  - Push 2: xor_in = 0x0000, op 010. Expect zero 1, parity 0.
  - Both delivered on consecutive cycles in order.
- Illegal opcode: op 101 with or_in = 0x1234.
  - Expect out_result 0x0000, err 1, zero 1, neg 0, parity 0.
  - result_count still increments on the pop.
- Backpressure: out_ready = 0, push NOR results 0x0001 then 0x8000.
  - in_ready = 0 after the second push, and a third in_valid is not accepted.
  - Raise out_ready: outputs 0x0001 (parity 1), then 0x8000 (neg 1). in_ready returns 1 the cycle after the first pop.
- Simultaneous push/pop at count 1: stream 8 XOR results 0x0003, 0x0007, … with both valid and ready held high.
  - One result per cycle, in order, with count staying 1.
  - result_count = 8 at the end.
- Reset and wrap:
  - Preload result_count to 0xFFFF through 65535 pops, then pop once more. Expect result_count = 0x0000.
  - With 2 entries queued, assert rst_n = 0 for one edge. Expect out_valid 0, in_ready 1, all outputs 0.
